// File: rtl/ram_pkg.sv
// Shared types and lane helpers for the data-memory subsystem (ram_top).
package ram_pkg;

    localparam int BLOCK_DATA_WIDTH = 128;
    localparam int OFFSET_W         = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        sign;
        logic [1:0]  width;
    } req_t;

    function automatic logic [31:0] lane_extract(input logic [BLOCK_DATA_WIDTH-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off,
                                                 input logic [1:0] width, input logic sign);
        logic [31:0] word;
        logic [15:0] half;
        logic [7:0]  byte_v;
        word   = blk[{off[3:2], 5'b0} +: 32];
        half   = off[1] ? word[31:16] : word[15:0];
        byte_v = word[{off[1:0], 3'b0} +: 8];
        case (width)
            W_HALF:  lane_extract = {{16{sign & half[15]}}, half};
            W_BYTE:  lane_extract = {{24{sign & byte_v[7]}}, byte_v};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [BLOCK_DATA_WIDTH-1:0] lane_merge(input logic [BLOCK_DATA_WIDTH-1:0] blk,
                                                               input logic [OFFSET_W-1:0] off,
                                                               input logic [1:0] width,
                                                               input logic [31:0] wdata);
        lane_merge = blk;
        case (width)
            W_HALF:  lane_merge[{off[3:2], off[1], 4'b0} +: 16] = wdata[15:0];
            W_BYTE:  lane_merge[{off[3:0], 3'b0} +: 8]          = wdata[7:0];
            default: lane_merge[{off[3:2], 5'b0} +: 32]         = wdata;
        endcase
    endfunction

endpackage

// File: rtl/ram_block_mem.sv
// Backing RAM of 128-bit blocks; each accepted read or write responds after MEM_LATENCY cycles.
module ram_block_mem
    import ram_pkg::*;
#(
    parameter int MEM_BLOCKS  = 256,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = $clog2(MEM_BLOCKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    input  logic                        req_write_i,
    input  logic [ADDR_W-1:0]           req_addr_i,
    input  logic [BLOCK_DATA_WIDTH-1:0] req_data_i,
    output logic                        resp_ready_o,
    output logic [BLOCK_DATA_WIDTH-1:0] resp_data_o
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic [BLOCK_DATA_WIDTH-1:0] mem_q [MEM_BLOCKS];
    logic                        busy_q, write_q, accept;
    logic [CNT_W-1:0]            cnt_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [BLOCK_DATA_WIDTH-1:0] wdata_q;

    // A new request may be accepted on the same edge the previous one completes.
    assign accept       = req_valid_i && (!busy_q || resp_ready_o);
    assign resp_ready_o = busy_q && (cnt_q == '0);
    assign resp_data_o  = mem_q[addr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(MEM_LATENCY - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_data_i;
        end
        if (resp_ready_o && write_q) mem_q[addr_q] <= wdata_q;
    end

endmodule

// File: rtl/ram_top.sv
// Data memory: 2-way write-back/write-allocate cache over ram_block_mem.
// Define RAMTOP_CACHE_EN to build the cache; otherwise every access goes straight to the RAM.
module ram_top
    import ram_pkg::*;
#(
    parameter int SETS        = 4,
    parameter int MEM_BLOCKS  = 256,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] writeData,
    output logic [31:0] data,
    input  logic        sign,
    input  logic [1:0]  width,
    output logic        ready
);

    localparam int BA_W = $clog2(MEM_BLOCKS);

    state_e                      state_q, state_d;
    req_t                        req_q, req_d;
    logic [31:0]                 data_q, data_d;
    logic                        ready_q, ready_d;
    logic                        mem_req, mem_write, mem_resp;
    logic [BA_W-1:0]             mem_addr, req_blk;
    logic [BLOCK_DATA_WIDTH-1:0] mem_wdata, mem_rdata;

    assign req_blk = req_q.addr[OFFSET_W +: BA_W];
    assign data    = data_q;
    assign ready   = ready_q;

`ifdef RAMTOP_CACHE_EN
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    logic [1:0]                  valid_q [SETS];
    logic [1:0]                  dirty_q [SETS];
    logic [SETS-1:0]             lru_q;
    logic [TAG_W-1:0]            tag_q  [SETS][2];
    logic [BLOCK_DATA_WIDTH-1:0] line_q [SETS][2];
    logic [IDX_W-1:0]            idx;
    logic [TAG_W-1:0]            tag;
    logic                        hit0, hit1, hit, hit_way, victim;
    logic                        sent_q, sent_d, hit_en, fill_en, clr_dirty;
    logic [BA_W-1:0]             victim_blk;

    assign idx        = req_q.addr[OFFSET_W +: IDX_W];
    assign tag        = req_q.addr[31 -: TAG_W];
    assign hit0       = valid_q[idx][0] && (tag_q[idx][0] == tag);
    assign hit1       = valid_q[idx][1] && (tag_q[idx][1] == tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = !hit0;
    assign victim     = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);
    assign victim_blk = BA_W'({tag_q[idx][victim], idx});
`else
    logic unused_addr;
    localparam int unused_sets = SETS;
    assign unused_addr = ^req_q.addr[31:OFFSET_W+BA_W];
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = req_blk;
`ifdef RAMTOP_CACHE_EN
        mem_wdata = line_q[idx][victim];
        hit_en    = 1'b0;
        fill_en   = 1'b0;
        clr_dirty = 1'b0;
`else
        mem_wdata = lane_merge(mem_rdata, req_q.addr[OFFSET_W-1:0], req_q.width, req_q.wdata);
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    req_d   = '{addr, write, writeData, sign, width};
                    state_d = COMPARE;
                end
            end
`ifdef RAMTOP_CACHE_EN
            COMPARE: begin
                if (hit) begin
                    hit_en = 1'b1;
                    if (!req_q.write)
                        data_d = lane_extract(line_q[idx][hit_way], req_q.addr[OFFSET_W-1:0],
                                              req_q.width, req_q.sign);
                    state_d = DONE;
                end else begin
                    mem_req = 1'b1;
                    if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                        mem_write = 1'b1;
                        mem_addr  = victim_blk;
                        state_d   = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_resp) begin
                    clr_dirty = 1'b1;
                    state_d   = ALLOCATE;
                end
            end
            // Entered from WRITEBACK the fill read has not been issued yet.
            ALLOCATE: begin
                mem_req = !sent_q;
                if (mem_resp) begin
                    fill_en = 1'b1;
                    state_d = COMPARE;
                end
            end
`else
            COMPARE: begin
                mem_req = 1'b1;
                state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (mem_resp) begin
                    if (req_q.write) begin
                        mem_req   = 1'b1;
                        mem_write = 1'b1;
                        state_d   = WRITEBACK;
                    end else begin
                        data_d  = lane_extract(mem_rdata, req_q.addr[OFFSET_W-1:0],
                                               req_q.width, req_q.sign);
                        state_d = DONE;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_resp) state_d = DONE;
            end
`endif
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef RAMTOP_CACHE_EN
        sent_d = sent_q;
        if (mem_resp) sent_d = 1'b0;
        if (mem_req)  sent_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) req_q <= req_d;

`ifdef RAMTOP_CACHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q <= 1'b0;
            lru_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            sent_q <= sent_d;
            if (fill_en) begin
                valid_q[idx][victim] <= 1'b1;
                dirty_q[idx][victim] <= 1'b0;
            end
            if (clr_dirty) dirty_q[idx][victim] <= 1'b0;
            if (hit_en) begin
                lru_q[idx] <= ~hit_way;
                if (req_q.write) dirty_q[idx][hit_way] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx][victim]  <= tag;
            line_q[idx][victim] <= mem_rdata;
        end
        if (hit_en && req_q.write)
            line_q[idx][hit_way] <= lane_merge(line_q[idx][hit_way], req_q.addr[OFFSET_W-1:0],
                                               req_q.width, req_q.wdata);
    end
`endif

    ram_block_mem #(
        .MEM_BLOCKS (MEM_BLOCKS),
        .MEM_LATENCY(MEM_LATENCY),
        .ADDR_W     (BA_W)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (mem_req),
        .req_write_i (mem_write),
        .req_addr_i  (mem_addr),
        .req_data_i  (mem_wdata),
        .resp_ready_o(mem_resp),
        .resp_data_o (mem_rdata)
    );

endmodule

// File: tb/tb_ram_top.sv
// Scoreboard bench for ram_top: byte-level memory model predicts load data and access latency.
module tb_ram_top;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst, valid, write, sign, ready;
    logic [31:0] addr, writeData, data;
    logic [1:0]  width;

    ram_top #(.SETS(4), .MEM_BLOCKS(256), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .write(write),
        .writeData(writeData), .data(data), .sign(sign), .width(width), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int unsigned issue;
        int          id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          nreq = 0;
    int unsigned cyc = 0;
    bit [7:0]    mem_m [int unsigned];
    logic [31:0] data_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s req%0d: got %h expected %h", nm, id, act, req);
        end
    endtask

    // RAM model: 256 blocks of 16 bytes, addresses wrap at 4 KiB.
    function automatic bit [7:0] rdb(input int unsigned a);
        int unsigned k = a & 32'hfff;
        return mem_m.exists(k) ? mem_m[k] : 8'h00;
    endfunction

    function automatic void wrb(input int unsigned a, input bit [7:0] v);
        mem_m[a & 32'hfff] = v;
    endfunction

    function automatic logic [31:0] m_load(input int unsigned a, input bit s, input bit [1:0] wi);
        bit [15:0] h;
        bit [7:0]  b;
        int unsigned a2 = a & ~32'd1;
        int unsigned a4 = a & ~32'd3;
        case (wi)
            2'b01: begin
                h = {rdb(a2 + 1), rdb(a2)};
                return s ? {{16{h[15]}}, h} : {16'h0, h};
            end
            2'b10: begin
                b = rdb(a);
                return s ? {{24{b[7]}}, b} : {24'h0, b};
            end
            default: return {rdb(a4 + 3), rdb(a4 + 2), rdb(a4 + 1), rdb(a4)};
        endcase
    endfunction

    function automatic void m_store(input int unsigned a, input bit [1:0] wi, input bit [31:0] wd);
        int unsigned a2 = a & ~32'd1;
        int unsigned a4 = a & ~32'd3;
        case (wi)
            2'b01: begin wrb(a2, wd[7:0]); wrb(a2 + 1, wd[15:8]); end
            2'b10: wrb(a, wd[7:0]);
            default: for (int i = 0; i < 4; i++) wrb(a4 + i, wd[8*i +: 8]);
        endcase
    endfunction

`ifdef RAMTOP_CACHE_EN
    bit          cv [4][2];
    bit          cd [4][2];
    int unsigned ct [4][2];
    bit          clru [4];

    function automatic void m_reset();
        for (int s = 0; s < 4; s++) begin
            clru[s] = 0;
            for (int w = 0; w < 2; w++) begin cv[s][w] = 0; cd[s][w] = 0; end
        end
    endfunction

    // Hit 3 cycles; clean miss adds L+1; dirty miss adds 2L+2.
    function automatic int m_latency(input int unsigned a, input bit w);
        int unsigned s = (a >> 4) & 3;
        int unsigned t = a >> 6;
        int v;
        int lat;
        for (int i = 0; i < 2; i++)
            if (cv[s][i] && ct[s][i] == t) begin
                clru[s] = (i == 0);
                if (w) cd[s][i] = 1;
                return 3;
            end
        v = !cv[s][0] ? 0 : (!cv[s][1] ? 1 : int'(clru[s]));
        lat = (cv[s][v] && cd[s][v]) ? 3 + 2*L + 2 : 3 + L + 1;
        cv[s][v] = 1; cd[s][v] = w; ct[s][v] = t; clru[s] = (v == 0);
        return lat;
    endfunction
`else
    function automatic void m_reset();
    endfunction

    function automatic int m_latency(input int unsigned a, input bit w);
        return w ? 2*L + 3 : L + 3;
    endfunction
`endif

    task automatic do_req(input logic [31:0] a, input bit w, input logic [31:0] wd,
                          input bit s, input bit [1:0] wi);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        e.lat = m_latency(a, w);
        if (w) m_store(a, wi, wd);
        else   data_m = m_load(a, s, wi);
        e.data  = data_m;
        e.issue = cyc;
        e.id    = nreq++;
        sb.push_back(e);
        valid = 1'b1; addr = a; write = w; writeData = wd; sign = s; width = wi;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 200);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL timeout req%0d: no ready within %0d cycles, required one", e.id, n);
        end
        valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: ready=1 with no request outstanding, required 0");
            end else begin
                mon_e = sb.pop_front();
                chk("data", mon_e.id, data, mon_e.data);
                chk("latency", mon_e.id, cyc - mon_e.issue, mon_e.lat);
            end
        end
    end

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        data_m = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = 1'b0; addr = '0; write = 1'b0; writeData = '0; sign = 1'b0; width = 2'b00;
        data_m = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", -1, {31'b0, ready}, 32'h0);
        chk("reset_data", -1, data, 32'h0);

        do_req(32'd8, 0, 32'h0, 0, 2'b00);

        // Abort a miss mid-fill; nothing may complete and the line must miss again.
        @(posedge clk); #1;
        valid = 1'b1; addr = 32'h100; write = 1'b0; width = 2'b00;
        repeat (3) @(negedge clk);
        pulse_reset();
        valid = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            @(negedge clk);
            chk("abort_ready", -1, {31'b0, ready}, 32'h0);
        end
        chk("abort_data", -1, data, 32'h0);
        do_req(32'h100, 0, 32'h0, 0, 2'b00);

        do_req(32'd8, 0, 32'h0, 0, 2'b00);
        do_req(32'd8, 1, 32'haabbccdd, 0, 2'b00);
        do_req(32'd8, 0, 32'h0, 0, 2'b00);
        do_req(32'd256, 0, 32'h0, 0, 2'b00);
        do_req(32'd512, 0, 32'h0, 0, 2'b00);
        do_req(32'd8, 0, 32'h0, 0, 2'b00);

        do_req(32'd0, 1, 32'habcd7faf, 0, 2'b10);
        do_req(32'd0, 1, 32'h0000f0f0, 0, 2'b01);
        do_req(32'd0, 1, 32'habcd7faf, 0, 2'b00);
        do_req(32'd0, 0, 32'h0, 1, 2'b10);
        do_req(32'd0, 0, 32'h0, 1, 2'b01);
        do_req(32'd0, 0, 32'h0, 0, 2'b10);
        do_req(32'd0, 0, 32'h0, 0, 2'b01);
        do_req(32'd0, 0, 32'h0, 0, 2'b00);
        do_req(32'd3, 0, 32'h0, 1, 2'b11);

        for (int i = 0; i < 80; i++)
            do_req(($urandom_range(0, 15) << 4) | $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", -1, sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
